// File: rtl/rv32_muldiv.sv
// Multi-cycle RV32M multiply/divide unit with fixed per-class latency.
// Operands are latched at acceptance; the result is computed from the latched copy and registered at the final count.
module rv32_muldiv #(
    parameter int DATA_WIDTH   = 32,
    parameter int MUL_CYCLES   = 3,
    parameter int DIV_CYCLES   = 5,
    parameter int TAG_WIDTH    = 5,
    parameter int FAST_SPECIAL = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] rs1,
    input  logic [DATA_WIDTH-1:0] rs2,
    input  logic [TAG_WIDTH-1:0]  tag_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic [TAG_WIDTH-1:0]  tag_out,
    output logic                  busy
);
    localparam int W       = DATA_WIDTH;
    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);
    localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt;
    logic [2:0]     op_q;
    logic [W-1:0]   a_q, b_q;
    logic [TAG_WIDTH-1:0] tag_q;
    logic           accept, last, fast_in;
    logic [CW-1:0]  load_cnt;

    assign accept = in_valid && in_ready;
    assign last   = (state == BUSY) && (cnt == CW'(1));

    // Specials are detected on the live operands so the counter can be loaded with 1.
    always_comb begin
        fast_in = 1'b0;
        if (FAST_SPECIAL == 1 && op[2])
            fast_in = (rs2 == '0) || (!op[0] && rs1 == SMIN && rs2 == '1);
        if (fast_in)
            load_cnt = CW'(1);
        else if (op[2])
            load_cnt = CW'(DIV_CYCLES);
        else
            load_cnt = CW'(MUL_CYCLES);
    end

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (in_valid) state_nxt = BUSY;
                BUSY:    if (cnt == CW'(1)) state_nxt = DONE;
                DONE:    if (out_ready) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        in_ready = (state == IDLE) && !flush;
        busy     = (state != IDLE);
    end

    // Arithmetic on the latched operands
    logic           a_sgn, b_sgn;
    logic [2*W-1:0] ext_a, ext_b, prod;
    logic           neg_a, neg_b;
    logic [W-1:0]   abs_a, abs_b, den, q_u, r_u, quo, rem, calc;

    always_comb begin
        a_sgn = (op_q[1:0] != 2'b11);
        b_sgn = (op_q[1:0] == 2'b00) || (op_q[1:0] == 2'b01);
        ext_a = {{W{a_sgn & a_q[W-1]}}, a_q};
        ext_b = {{W{b_sgn & b_q[W-1]}}, b_q};
        prod  = ext_a * ext_b;

        neg_a = !op_q[0] && a_q[W-1];
        neg_b = !op_q[0] && b_q[W-1];
        abs_a = neg_a ? (~a_q + 1'b1) : a_q;
        abs_b = neg_b ? (~b_q + 1'b1) : b_q;
        den   = (b_q == '0) ? {{(W-1){1'b0}}, 1'b1} : abs_b;
        q_u   = abs_a / den;
        r_u   = abs_a % den;
        quo   = (neg_a ^ neg_b) ? (~q_u + 1'b1) : q_u;
        rem   = neg_a ? (~r_u + 1'b1) : r_u;

        if (!op_q[2]) begin
            calc = (op_q[1:0] == 2'b00) ? prod[W-1:0] : prod[2*W-1:W];
        end else if (b_q == '0) begin
            calc = op_q[1] ? a_q : '1;
        end else if (!op_q[0] && a_q == SMIN && b_q == '1) begin
            calc = op_q[1] ? '0 : a_q;
        end else begin
            calc = op_q[1] ? rem : quo;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            tag_q     <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            tag_out   <= '0;
        end else begin
            if (flush) begin
                cnt       <= '0;
                out_valid <= 1'b0;
            end else if (accept) begin
                op_q  <= op;
                a_q   <= rs1;
                b_q   <= rs2;
                tag_q <= tag_in;
                cnt   <= load_cnt;
            end else if (state == BUSY) begin
                cnt <= cnt - 1'b1;
                if (last) begin
                    out_valid <= 1'b1;
                    result    <= calc;
                    tag_out   <= tag_q;
                end
            end else if (state == DONE && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rv32_muldiv.sv
// Bench for rv32_muldiv: directed test-plan cases, flush/reset/backpressure cases and a random sweep
// compared against a 64-bit integer reference model.
module tb_rv32_muldiv;
    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready, busy;
    logic [2:0]  op;
    logic [31:0] rs1, rs2, result;
    logic [4:0]  tag_in, tag_out;
    int checks = 0;
    int errors = 0;

    rv32_muldiv dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .rs1(rs1), .rs2(rs2), .tag_in(tag_in), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .tag_out(tag_out), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", nm, got, expv);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p;
        longint unsigned ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (o)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin up = ua * ub; return up[63:32]; end
            3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
            3'd5: begin if (b == 0) return 32'hFFFF_FFFF; up = ua / ub; return up[31:0]; end
            3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
            default: begin if (b == 0) return a; up = ua % ub; return up[31:0]; end
        endcase
    endfunction

    function automatic int lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        bit is_div, is_signed_div, ovf;
        is_div        = (o >= 3'd4);
        is_signed_div = (o == 3'd4) || (o == 3'd6);
        ovf           = is_signed_div && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
        if (is_div && (b == 0 || ovf)) return 1;
        return is_div ? 5 : 3;
    endfunction

    // Issues one op, scrambles inputs after acceptance, waits for the result and checks it.
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] t, input string nm);
        int n;
        @(negedge clk);
        op = o; rs1 = a; rs2 = b; tag_in = t; in_valid = 1'b1;
        chk($sformatf("%s in_ready", nm), 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        rs1 = $urandom; rs2 = $urandom; op = 3'($urandom); tag_in = 5'($urandom);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk($sformatf("%s latency", nm), 64'(n), 64'(lat(o, a, b)));
        chk($sformatf("%s result", nm), 64'(result), 64'(model(o, a, b)));
        chk($sformatf("%s tag", nm), 64'(tag_out), 64'(t));
        if (out_ready) begin
            @(posedge clk); #1;
            chk($sformatf("%s consumed", nm), 64'(out_valid), 64'd0);
        end
    endtask

    initial begin
        int seen;
        logic [31:0] a, b;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = '0; rs1 = '0; rs2 = '0; tag_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst result", 64'(result), 64'd0);
        chk("rst tag_out", 64'(tag_out), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst in_ready", 64'(in_ready), 64'd1);
        @(negedge clk); rst = 1'b0;

        do_op(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd3, "mul");
        do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd4, "mulh");
        do_op(3'd3, 32'h8000_0000, 32'h8000_0000, 5'd5, "mulhu");
        do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, "mulhsu");
        do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd7, "div");
        do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd8, "rem");
        do_op(3'd5, 32'd7, 32'd0, 5'd9, "divu0");
        do_op(3'd7, 32'd7, 32'd0, 5'd10, "remu0");
        do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, "div_ovf");
        do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, "rem_ovf");

        // backpressure: result held for 4 cycles
        out_ready = 1'b0;
        do_op(3'd0, 32'd6, 32'd7, 5'd13, "hold");
        repeat (4) begin
            @(posedge clk); #1;
            chk("hold out_valid", 64'(out_valid), 64'd1);
            chk("hold result", 64'(result), 64'd42);
            chk("hold tag", 64'(tag_out), 64'd13);
            chk("hold in_ready", 64'(in_ready), 64'd0);
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1;
        chk("release out_valid", 64'(out_valid), 64'd0);
        chk("release in_ready", 64'(in_ready), 64'd1);
        do_op(3'd5, 32'd100, 32'd7, 5'd14, "after_hold");

        // flush together with out_ready in DONE
        out_ready = 1'b0;
        do_op(3'd0, 32'd3, 32'd5, 5'd15, "flush_done");
        @(negedge clk); flush = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("flush_done out_valid", 64'(out_valid), 64'd0);
        chk("flush_done busy", 64'(busy), 64'd0);
        @(negedge clk); flush = 1'b0;

        // flush at edge 2 of a DIV
        @(negedge clk);
        op = 3'd4; rs1 = 32'd100; rs2 = 32'd3; tag_in = 5'd16; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk); flush = 1'b1;
        chk("flush in_ready busy", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        chk("flush busy", 64'(busy), 64'd0);
        chk("flush in_ready", 64'(in_ready), 64'd0);
        @(negedge clk); flush = 1'b0; #1;
        chk("post flush in_ready", 64'(in_ready), 64'd1);
        seen = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("flushed never valid", 64'(seen), 64'd0);
        do_op(3'd0, 32'd11, 32'd13, 5'd17, "post_flush_mul");

        // async reset mid-BUSY
        @(negedge clk);
        op = 3'd0; rs1 = 32'd5; rs2 = 32'd5; tag_in = 5'd18; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1; #1;
        chk("async rst out_valid", 64'(out_valid), 64'd0);
        chk("async rst result", 64'(result), 64'd0);
        chk("async rst tag", 64'(tag_out), 64'd0);
        chk("async rst busy", 64'(busy), 64'd0);
        chk("async rst in_ready", 64'(in_ready), 64'd1);
        @(negedge clk); rst = 1'b0;

        // random sweep with operands biased toward the special cases
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: a = 32'h8000_0000;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 4))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            do_op(3'($urandom), a, b, 5'($urandom), $sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rv32_muldiv.md
# rv32_muldiv

Multi-cycle RV32M multiply/divide unit for the CPU execute stage, parametrised in data width and per-class latency. It accepts one operation per valid/ready handshake and returns the result with its destination tag after a fixed, class-dependent number of cycles. Optionally, divide special cases return early. The execute stage may flush it at any time.

## Interface
- DATA_WIDTH, 32: operand and result width (even, ≥8).
- MUL_CYCLES, 3: acceptance-to-result latency for MUL/MULH/MULHSU/MULHU (≥1).
- DIV_CYCLES, 5: acceptance-to-result latency for DIV/DIVU/REM/REMU (≥1).
- TAG_WIDTH, 5: width of the destination tag carried with the operation.
- FAST_SPECIAL, 1: when 1, divide-by-zero and signed overflow complete with latency 1.

- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  abort the in-flight operation; no result is produced
- in_valid  in  1  operation request
- in_ready  out  1  unit can accept; equals (state==IDLE) && !flush
- op  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1  in  DATA_WIDTH  operand A (dividend / multiplicand)
- rs2  in  DATA_WIDTH  operand B (divisor / multiplier)
- tag_in  in  TAG_WIDTH  destination tag
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- result  out  DATA_WIDTH  result value
- tag_out  out  TAG_WIDTH  tag captured at acceptance
- busy  out  1  state != IDLE

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: accept on in_valid && in_ready. Latch op, rs1, rs2 and tag_in. Load the latency counter with L = MUL_CYCLES or DIV_CYCLES, or 1 for fast specials. Go to BUSY.
- BUSY: the counter decrements once per cycle. When the counter reaches its final count, result and tag_out are registered, out_valid=1, and the state goes to DONE. Implementation (array, iterative, or compute-then-delay) is free; only the latency is fixed.
- DONE: hold result, tag_out and out_valid stable until out_ready=1. Go to IDLE on the edge where out_valid && out_ready.
- flush (any state): next edge goes to IDLE with out_valid=0. The flushed operation never appears. In IDLE, flush forces in_ready=0, so nothing is accepted.
- Arithmetic, with W = DATA_WIDTH and a 2W-bit product:
  - MUL returns the low W bits of the product.
  - MULH returns the high W bits of signed × signed.
  - MULHSU returns the high W bits of signed rs1 × unsigned rs2.
  - MULHU returns the high W bits of unsigned × unsigned.
- Divide rounds toward zero. The remainder takes the sign of the dividend.
- Divide by zero (rs2==0):
  - DIV/DIVU return all ones.
  - REM/REMU return rs1.
- Signed overflow (rs1 = −2^(W−1), rs2 = −1):
  - DIV returns rs1.
  - REM returns 0.
- Fast specials apply only to the divide-by-zero and signed-overflow cases of signed/unsigned div/rem, and only when FAST_SPECIAL=1.

## Timing
- Reset values: state IDLE, so in_ready=1 (while flush=0). out_valid=0, result=0, tag_out=0, busy=0, counter=0.
- Accept edge = cycle 0. out_valid is first high after edge L, so latency is L cycles with no bubbles.
- Example: a MUL accepted at edge 0 with MUL_CYCLES=3 has out_valid rising at edge 3.
- in_ready is low from the accept edge until the edge after the result handshake. Back-to-back issue therefore costs L+1 cycles minimum when out_ready is held high.
- Outputs are registered. in_ready is combinational only from state and flush.
- flush and out_ready in the same DONE cycle: the result counts as consumed, and the state goes to IDLE.
- Reset asserted mid-operation: all outputs return to their reset values immediately (async). The operation is lost.
- Changes to rs1, rs2, op or tag_in after acceptance do not affect the result.

## Test plan
- Reset, then MUL rs1=0x0000_0007, rs2=0xFFFF_FFFD, tag 3 -> out_valid rises at edge 3, result=0xFFFF_FFEB, tag_out=3.
- MULH rs1=0x8000_0000, rs2=0x8000_0000 -> 0x4000_0000. MULHU with the same operands -> 0x4000_0000. MULHSU rs1=0xFFFF_FFFF, rs2=0xFFFF_FFFF -> 0xFFFF_FFFF.
- DIV rs1=0xFFFF_FFF9 (−7), rs2=2 -> 0xFFFF_FFFD at edge 5. REM with the same operands -> 0xFFFF_FFFF. DIVU 7/0 -> 0xFFFF_FFFF at edge 1 (FAST_SPECIAL=1). REMU 7/0 -> 7.
- DIV 0x8000_0000 / 0xFFFF_FFFF -> 0x8000_0000. REM with the same operands -> 0.
- Hold out_ready=0 for 4 cycles after completion -> result, tag_out and out_valid stay stable and in_ready=0. Then out_ready=1 -> IDLE next edge, and a new op is accepted the following cycle.
- Flush at edge 2 of a DIV -> no out_valid ever for it. in_ready=0 during the flush cycle and 1 on the next cycle. A following MUL completes normally. Asserting rst mid-BUSY drops all outputs to reset values asynchronously.
